// File: rtl/aes_arb_pkg.sv
// Shared encodings for the AES engine arbiter: key lengths, FSM states, direction.
package aes_arb_pkg;
  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } keylen_e;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic DIR_ENC = 1'b0;
  localparam logic DIR_DEC = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  int          kk;
  logic [IW-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    kk  = 0;
    k   = '0;
    for (int i = 0; i < NREQ; i++) begin
      kk = (int'(ptr) + i) % NREQ;
      k  = IW'(kk);
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end
endmodule

// File: rtl/aes_engine_arbiter.sv
// Round-robin front end sharing one AES engine: latch winner's operands, run one job,
// return the result (or an error on illegal keylen / timeout) to the winner.
module aes_engine_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_keylen,
  input  logic [NREQ-1:0]     req_dir,
  input  logic [256*NREQ-1:0] req_key,
  input  logic [128*NREQ-1:0] req_data,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [127:0]        rsp_data,
  output logic                rsp_err,
  output logic                eng_start,
  output logic                eng_abort,
  output logic [1:0]          eng_keylen,
  output logic                eng_dir,
  output logic [255:0]        eng_key,
  output logic [127:0]        eng_data,
  input  logic                eng_done,
  input  logic [127:0]        eng_result
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state, state_nx;
  logic [IW-1:0]   rr_ptr, g, gidx;
  logic [NREQ-1:0] gnt;
  logic            any, accept, timeout_hit;
  logic [CW-1:0]   cnt;
  logic [1:0]      sel_keylen;
  logic            sel_dir;
  logic [255:0]    sel_key;
  logic [127:0]    sel_data;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .gnt(gnt), .idx(gidx), .any(any)
  );

  assign sel_keylen  = req_keylen[int'(gidx)*2 +: 2];
  assign sel_dir     = req_dir[gidx];
  assign sel_key     = req_key[int'(gidx)*256 +: 256];
  assign sel_data    = req_data[int'(gidx)*128 +: 128];
  // Last WAIT cycle before abort; a same-cycle eng_done takes priority.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    accept    = 1'b0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    rsp_valid = '0;
    case (state)
      S_IDLE: if (reset) begin
        req_ready = gnt;
        if (any) begin
          accept   = 1'b1;
          state_nx = (sel_keylen == KL_BAD) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) state_nx = S_RESP;
        else if (timeout_hit) begin
          eng_abort = 1'b1;
          state_nx  = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[g] = 1'b1;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr     <= '0;
      g          <= '0;
      cnt        <= '0;
      eng_keylen <= '0;
      eng_dir    <= 1'b0;
      eng_key    <= '0;
      eng_data   <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        g          <= gidx;
        eng_keylen <= sel_keylen;
        eng_dir    <= sel_dir;
        eng_key    <= sel_key;
        eng_data   <= sel_data;
        if (sel_keylen == KL_BAD) begin
          rsp_err  <= 1'b1;
          rsp_data <= '0;
        end
      end
      if (state == S_ISSUE) cnt <= '0;
      if (state == S_WAIT) begin
        if (eng_done) begin
          rsp_data <= eng_result;
          rsp_err  <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
          if (timeout_hit) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end
        end
      end
      if (state == S_RESP) rr_ptr <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
    end
  end
endmodule
